mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter between the instruction fetcher and the load/store buffer.
// Multi-byte accesses are split into single-byte RAM cycles with one cycle of read latency.
module mem_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic [3:0]  lsb_type,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata
);

    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

    state_t      state, state_next;
    logic [2:0]  cnt;
    logic [2:0]  len;
    logic [2:0]  cnt_m1;
    logic [2:0]  funct3;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] rbuf;
    logic [31:0] merged;
    logic        last_lsb;
    logic        replay;
    logic        reading;
    logic        rd_last;
    logic        issue_rd;
    logic        issue_wr;
    logic        if_cand;
    logic        lsb_cand;
    logic        grant_if;
    logic        grant_lsb;

    function automatic logic [2:0] len_of(input logic [1:0] size);
        case (size)
            2'b00:   len_of = 3'd1;
            2'b01:   len_of = 3'd2;
            default: len_of = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  extend = {{24{w[7]}}, w[7:0]};
            3'b001:  extend = {{16{w[15]}}, w[15:0]};
            3'b100:  extend = {24'd0, w[7:0]};
            3'b101:  extend = {16'd0, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    // A requester whose done pulse is high this cycle is still holding req; mask it out.
    always_comb begin
        if_cand   = if_req && !clear_in && !if_done;
        lsb_cand  = lsb_req && (lsb_type[3] || !clear_in) && !lsb_done;
        grant_lsb = lsb_cand && (!if_cand || !last_lsb);
        grant_if  = if_cand && !grant_lsb;
    end

    always_comb begin
        reading  = (state == IF_RD) || (state == LS_RD);
        rd_last  = reading && !replay && (cnt == len);
        issue_rd = reading && !replay && (cnt < len);
        issue_wr = (state == LS_WR) && !((base[17:16] == 2'b11) && io_buffer_full);
        cnt_m1   = cnt - 3'd1;
        merged   = rbuf;
        if (cnt != 3'd0) merged[8*cnt_m1[1:0] +: 8] = mem_din;
    end

    // After a stall the RAM output no longer matches the byte we expect, so the
    // previous address is re-issued for one cycle before sampling resumes.
    always_comb begin
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        if (reading && replay) begin
            mem_a = base + {29'd0, cnt} - 32'd1;
        end else if (issue_rd) begin
            mem_a = base + {29'd0, cnt};
        end else if (issue_wr) begin
            mem_a    = base + {29'd0, cnt};
            mem_dout = wdata[8*cnt[1:0] +: 8];
            mem_wr   = rdy_in;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_if)       state_next = IF_RD;
                else if (grant_lsb) state_next = lsb_type[3] ? LS_WR : LS_RD;
            end
            IF_RD, LS_RD: begin
                if (clear_in || rd_last) state_next = IDLE;
            end
            LS_WR: begin
                if (issue_wr && (cnt == len - 3'd1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            len       <= 3'd0;
            funct3    <= 3'd0;
            base      <= 32'd0;
            wdata     <= 32'd0;
            rbuf      <= 32'd0;
            last_lsb  <= 1'b0;
            replay    <= 1'b0;
            if_done   <= 1'b0;
            lsb_done  <= 1'b0;
            if_data   <= 32'd0;
            lsb_rdata <= 32'd0;
        end else begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            if (!rdy_in) begin
                if (reading && (cnt != 3'd0)) replay <= 1'b1;
            end else begin
                state <= state_next;
                case (state)
                    IDLE: begin
                        cnt    <= 3'd0;
                        replay <= 1'b0;
                        if (grant_if) begin
                            base     <= if_addr;
                            len      <= 3'd4;
                            last_lsb <= 1'b0;
                        end else if (grant_lsb) begin
                            base     <= lsb_addr;
                            wdata    <= lsb_wdata;
                            funct3   <= lsb_type[2:0];
                            len      <= len_of(lsb_type[1:0]);
                            last_lsb <= 1'b1;
                        end
                    end
                    IF_RD, LS_RD: begin
                        if (clear_in) begin
                            cnt    <= 3'd0;
                            replay <= 1'b0;
                        end else if (replay) begin
                            replay <= 1'b0;
                        end else begin
                            if (cnt != 3'd0) rbuf <= merged;
                            if (cnt == len) begin
                                cnt <= 3'd0;
                                if (state == IF_RD) begin
                                    if_done <= 1'b1;
                                    if_data <= merged;
                                end else begin
                                    lsb_done  <= 1'b1;
                                    lsb_rdata <= extend(funct3, merged);
                                end
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end
                    LS_WR: begin
                        if (issue_wr) begin
                            if (cnt == len - 3'd1) begin
                                cnt      <= 3'd0;
                                lsb_done <= 1'b1;
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end
                    default: cnt <= 3'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte RAM with one-cycle read latency sits behind the DUT,
// inputs are driven on the falling edge and outputs checked 1 ns later.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        lsb_req, lsb_done;
    logic [3:0]  lsb_type;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;

    logic [7:0]  ram [0:4095];
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;
    int          lat;
    logic [31:0] word;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_type(lsb_type), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous RAM: the address seen at an edge is returned on mem_din for the next cycle.
    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic lr,
                                 input logic [3:0] lt, input logic [31:0] la, input logic [31:0] lw);
        if_req    = ifr;
        if_addr   = ifa;
        lsb_req   = lr;
        lsb_type  = lt;
        lsb_addr  = la;
        lsb_wdata = lw;
    endtask

    task automatic nextCycle();
        @(negedge clk_in);
    endtask

    task automatic waitDone(input bit want_if, input int limit, output int cycles);
        cycles = -1;
        for (int k = 1; k <= limit; k++) begin
            nextCycle();
            #1;
            if (want_if ? if_done : lsb_done) begin
                cycles = k;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
        ram[12'h200] = 8'h11; ram[12'h201] = 8'h22; ram[12'h202] = 8'h33; ram[12'h203] = 8'h44;
        ram[12'h020] = 8'h80;

        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (2) nextCycle();
        rst_in = 1'b0;
        #1;
        checkOutput("reset mem_a", mem_a, 32'd0);
        checkOutput("reset mem_wr", {31'd0, mem_wr}, 32'd0);
        checkOutput("reset mem_dout", {24'd0, mem_dout}, 32'd0);
        checkOutput("reset dones", {30'd0, if_done, lsb_done}, 32'd0);
        checkOutput("reset if_data", if_data, 32'd0);
        checkOutput("reset lsb_rdata", lsb_rdata, 32'd0);

        // Tie right after reset: LSB first, then IF.
        nextCycle();
        applyStimulus(1'b1, 32'h100, 1'b1, 4'b0000, 32'h20, 32'd0);
        nextCycle(); #1;
        checkOutput("tie first grant addr", mem_a, 32'h20);
        waitDone(1'b0, 10, lat);
        checkOutput("tie lsb latency", lat, 32'd2);
        checkOutput("tie lsb data", lsb_rdata, 32'hFFFFFF80);
        lsb_req = 1'b0;
        nextCycle(); #1;
        checkOutput("tie second grant addr", mem_a, 32'h100);
        waitDone(1'b1, 10, lat);
        checkOutput("tie if latency", lat, 32'd5);
        checkOutput("tie if data", if_data, 32'h00000513);
        if_req = 1'b0;

        // Instruction fetch with exact cycle timing.
        nextCycle();
        applyStimulus(1'b1, 32'h100, 1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        checkOutput("if cycle0 mem_a", mem_a, 32'd0);
        for (int i = 0; i < 4; i++) begin
            nextCycle(); #1;
            checkOutput("if byte addr", mem_a, 32'h100 + i);
            checkOutput("if no write", {31'd0, mem_wr}, 32'd0);
        end
        nextCycle(); #1;
        checkOutput("if cycle5 done", {31'd0, if_done}, 32'd0);
        checkOutput("if cycle5 mem_a", mem_a, 32'd0);
        nextCycle(); #1;
        checkOutput("if cycle6 done", {31'd0, if_done}, 32'd1);
        checkOutput("if cycle6 data", if_data, 32'h00000513);
        if_req = 1'b0;
        nextCycle(); #1;
        checkOutput("if done pulse width", {31'd0, if_done}, 32'd0);
        checkOutput("if data hold", if_data, 32'h00000513);

        // LB and LBU of 0x80.
        applyStimulus(1'b0, 32'd0, 1'b1, 4'b0000, 32'h20, 32'd0);
        waitDone(1'b0, 10, lat);
        checkOutput("lb latency", lat, 32'd3);
        checkOutput("lb data", lsb_rdata, 32'hFFFFFF80);
        lsb_req = 1'b0;
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b1, 4'b0100, 32'h20, 32'd0);
        waitDone(1'b0, 10, lat);
        checkOutput("lbu latency", lat, 32'd3);
        checkOutput("lbu data", lsb_rdata, 32'h00000080);
        lsb_req = 1'b0;

        // SW of DEADBEEF at 0x40.
        nextCycle();
        word = 32'hDEADBEEF;
        applyStimulus(1'b0, 32'd0, 1'b1, 4'b1010, 32'h40, word);
        for (int i = 0; i < 4; i++) begin
            nextCycle(); #1;
            checkOutput("sw mem_wr", {31'd0, mem_wr}, 32'd1);
            checkOutput("sw mem_a", mem_a, 32'h40 + i);
            checkOutput("sw byte", {24'd0, mem_dout}, {24'd0, word[8*i +: 8]});
        end
        nextCycle(); #1;
        checkOutput("sw done", {31'd0, lsb_done}, 32'd1);
        checkOutput("sw wr off", {31'd0, mem_wr}, 32'd0);
        lsb_req = 1'b0;

        // SB to the IO window while the UART buffer is full.
        nextCycle();
        io_buffer_full = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b1, 4'b1000, 32'h30000, 32'h5A);
        for (int i = 0; i < 3; i++) begin
            nextCycle(); #1;
            checkOutput("io stall mem_wr", {31'd0, mem_wr}, 32'd0);
        end
        nextCycle();
        io_buffer_full = 1'b0;
        #1;
        checkOutput("io write mem_wr", {31'd0, mem_wr}, 32'd1);
        checkOutput("io write mem_a", mem_a, 32'h30000);
        checkOutput("io write byte", {24'd0, mem_dout}, 32'h5A);
        nextCycle(); #1;
        checkOutput("io done", {31'd0, lsb_done}, 32'd1);
        lsb_req = 1'b0;

        // Flush during an instruction read.
        nextCycle();
        applyStimulus(1'b1, 32'h100, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (2) nextCycle();
        nextCycle();
        clear_in = 1'b1; if_req = 1'b0;
        #1;
        checkOutput("flush pre addr", mem_a, 32'h102);
        nextCycle();
        clear_in = 1'b0;
        #1;
        checkOutput("flush idle addr", mem_a, 32'd0);
        for (int i = 0; i < 4; i++) begin
            nextCycle(); #1;
            checkOutput("flush no if_done", {31'd0, if_done}, 32'd0);
        end

        // Flush in IDLE blocks a fetch grant for that cycle only.
        applyStimulus(1'b1, 32'h100, 1'b0, 4'd0, 32'd0, 32'd0);
        clear_in = 1'b1;
        nextCycle();
        clear_in = 1'b0;
        #1;
        checkOutput("idle flush no grant", mem_a, 32'd0);
        nextCycle(); #1;
        checkOutput("grant after flush", mem_a, 32'h100);
        waitDone(1'b1, 10, lat);
        checkOutput("grant after flush latency", lat, 32'd5);
        if_req = 1'b0;

        // Flush during a store does not cancel it.
        nextCycle();
        applyStimulus(1'b0, 32'd0, 1'b1, 4'b1010, 32'h40, 32'h12345678);
        nextCycle(); #1;
        checkOutput("sw2 first write", {31'd0, mem_wr}, 32'd1);
        nextCycle();
        clear_in = 1'b1;
        #1;
        checkOutput("sw2 write under flush", {31'd0, mem_wr}, 32'd1);
        checkOutput("sw2 addr under flush", mem_a, 32'h41);
        nextCycle();
        clear_in = 1'b0;
        waitDone(1'b0, 10, lat);
        checkOutput("sw2 done latency", lat, 32'd2);
        lsb_req = 1'b0;
        checkOutput("sw2 ram contents", {ram[12'h43], ram[12'h42], ram[12'h41], ram[12'h40]}, 32'h12345678);

        // Two-cycle stall in the middle of a fetch.
        nextCycle();
        applyStimulus(1'b1, 32'h200, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (2) nextCycle();
        nextCycle();
        rdy_in = 1'b0;
        nextCycle();
        nextCycle();
        rdy_in = 1'b1;
        waitDone(1'b1, 12, lat);
        checkOutput("stall latency", lat, 32'd4);
        checkOutput("stall data", if_data, 32'h44332211);
        if_req = 1'b0;

        // Reset with rdy low in the middle of a fetch.
        nextCycle();
        applyStimulus(1'b1, 32'h200, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (2) nextCycle();
        rst_in = 1'b1; rdy_in = 1'b0; if_req = 1'b0;
        nextCycle(); #1;
        checkOutput("rst mid mem_a", mem_a, 32'd0);
        checkOutput("rst mid if_data", if_data, 32'd0);
        checkOutput("rst mid lsb_rdata", lsb_rdata, 32'd0);
        rst_in = 1'b0; rdy_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            nextCycle(); #1;
            checkOutput("rst abandoned no done", {31'd0, if_done}, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
